// File: rtl/calc_if.sv
// calc_if -- operand/command and result bundle for calc_engine.
//   master: drives In1, In2, keyboard, modo, start; observes results.
//   slave : the engine; drives answer, remainder, signal, flag_answer,
//           busy, done, err.
interface calc_if #(
  parameter int W  = 7,
  parameter int RW = 2*W
);
  logic [W-1:0]  In1;
  logic [W-1:0]  In2;
  logic [3:0]    keyboard;
  logic          modo;
  logic          start;
  logic [RW-1:0] answer;
  logic [W-1:0]  remainder;
  logic          signal;
  logic          flag_answer;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output In1, In2, keyboard, modo, start,
    input  answer, remainder, signal, flag_answer, busy, done, err
  );

  modport slave (
    input  In1, In2, keyboard, modo, start,
    output answer, remainder, signal, flag_answer, busy, done, err
  );
endinterface

// File: rtl/calc_engine.sv
// calc_engine -- small unsigned calculator: add/sub in one cycle, iterative
// shift-add multiply and restoring divide (one bit per cycle, W cycles).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : calc_if.slave -- operands/key/mode/start in, results and status out
// Key 13 with modo high clears results and aborts any operation in any state.
module calc_engine #(
  parameter int W  = 7,
  parameter int RW = 2*W
) (
  input logic   clk,
  input logic   rst,
  calc_if.slave bus
);
  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13;
  localparam logic [3:0] K_DIV = 4'd14;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [3:0]      op;
  logic [CW-1:0]   cnt;
  // mul: a = multiplier (shifts right), b = multiplicand (shifts left), acc = product
  // div: a = dividend in / quotient out, b[W-1:0] = divisor, acc[W-1:0] = partial remainder
  logic [W-1:0]    a, a_n;
  logic [2*W-1:0]  b, b_n, acc, acc_n;
  logic [W:0]      r_sh, r_sub;
  logic            ge;
  logic [W:0]      sum;
  logic [W-1:0]    diff;
  logic            accept;

  always_comb begin
    r_sh  = {acc[W-1:0], a[W-1]};
    r_sub = r_sh - {1'b0, b[W-1:0]};
    ge    = (r_sh >= {1'b0, b[W-1:0]});
    a_n   = a;
    b_n   = b;
    acc_n = acc;
    if (op == K_MUL) begin
      acc_n = acc + (a[0] ? b : '0);
      a_n   = a >> 1;
      b_n   = b << 1;
    end else begin
      acc_n = (2*W)'(ge ? r_sub : r_sh);
      a_n   = {a[W-2:0], ge};
    end
  end

  always_comb begin
    sum    = {1'b0, bus.In1} + {1'b0, bus.In2};
    diff   = (bus.In2 > bus.In1) ? (bus.In2 - bus.In1) : (bus.In1 - bus.In2);
    accept = bus.start && bus.modo && (bus.keyboard inside {K_ADD, K_SUB, K_MUL, K_DIV});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      op              <= '0;
      cnt             <= '0;
      a               <= '0;
      b               <= '0;
      acc             <= '0;
      bus.answer      <= '0;
      bus.remainder   <= '0;
      bus.signal      <= 1'b0;
      bus.flag_answer <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else if (bus.modo && bus.keyboard == K_CLR) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.answer      <= '0;
      bus.remainder   <= '0;
      bus.signal      <= 1'b0;
      bus.flag_answer <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op  <= bus.keyboard;
          cnt <= '0;
          a   <= bus.In1;
          b   <= (2*W)'(bus.In2);
          acc <= '0;
          if (bus.keyboard == K_MUL || (bus.keyboard == K_DIV && bus.In2 != '0)) begin
            state    <= CALC;
            bus.busy <= 1'b1;
          end else begin
            // add/sub and divide-by-zero finish without iterating
            state           <= DONE;
            bus.done        <= 1'b1;
            bus.flag_answer <= 1'b1;
            bus.remainder   <= '0;
            bus.signal      <= (bus.keyboard == K_SUB) && (bus.In2 > bus.In1);
            case (bus.keyboard)
              K_ADD:   bus.answer <= RW'(sum);
              K_SUB:   bus.answer <= RW'(diff);
              default: begin
                bus.answer <= '0;
                bus.err    <= 1'b1;
              end
            endcase
          end
        end
        CALC: begin
          a   <= a_n;
          b   <= b_n;
          acc <= acc_n;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W-1)) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.flag_answer <= 1'b1;
            bus.signal      <= 1'b0;
            if (op == K_MUL) begin
              bus.answer    <= RW'(acc_n);
              bus.remainder <= '0;
            end else begin
              bus.answer    <= RW'(a_n);
              bus.remainder <= acc_n[W-1:0];
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
